// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - dualport_bus interface between the fetch unit (master) and the instruction ROM (slave).
interface dualport_bus;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_gnt;
  logic [31:0] rd_data;
  logic        wr_req;

  modport master (output rd_req, output rd_addr, input rd_gnt, input rd_data, output wr_req);
  modport slave  (input rd_req, input rd_addr, output rd_gnt, output rd_data, input wr_req);
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: PC, credit-limited ROM reads, fetch FIFO, redirect flush.
// Optional FETCH_PERF_EN adds pop and stall performance counters.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  dualport_bus.master instr_master,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        fetch_busy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]   mem_data_q [FIFO_DEPTH];
  logic [31:0]   mem_pc_q   [FIFO_DEPTH];

  logic          push, pop, gnt, rd_req;
  logic [CW:0]   occupancy;
  logic          redirect_pc_unused;

  assign redirect_pc_unused = ^redirect_pc[1:0];

  assign instr_valid = (cnt_q != '0);
  assign pop         = instr_valid && instr_ready;
  assign push        = inflight_q && !redirect_valid;
  // Occupancy counts the word already in flight so a push can never find the FIFO full.
  assign occupancy   = {1'b0, cnt_q} - (CW + 1)'(pop) + (CW + 1)'(inflight_q);
  assign rd_req      = (state_q == RUN) && fetch_en && !redirect_valid && (occupancy < DEPTH_W);
  assign gnt         = rd_req && instr_master.rd_gnt;

  assign instr_master.rd_req  = rd_req;
  assign instr_master.rd_addr = pc_q;
  assign instr_master.wr_req  = 1'b0;

  assign instr_data = instr_valid ? mem_data_q[rd_ptr_q] : 32'h0;
  assign instr_pc   = instr_valid ? mem_pc_q[rd_ptr_q]   : 32'h0;
  assign fetch_busy = (state_q != IDLE) || instr_valid;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = gnt;
    inflight_pc_d = pc_q;
    cnt_d         = cnt_q + CW'(push) - CW'(pop);
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    if (gnt)  pc_d     = pc_q + 32'd4;

    case (state_q)
      IDLE:    if (fetch_en) state_d = RUN;
      RUN:     if (!fetch_en) state_d = inflight_q ? DRAIN : IDLE;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      cnt_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      cnt_q         <= cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= instr_master.rd_data;
      mem_pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  always_comb begin
    if (!rst) assert (!(push && !pop && cnt_q == FULL_CNT));
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q + 32'(pop);
    perf_stall_d = perf_stall_q + 32'((state_q == RUN) && !gnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= 32'h0;
      perf_stall_q <= 32'h0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch with a registered-data ROM slave.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        fetch_busy;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif
  int checks = 0;
  int errors = 0;

  dualport_bus bus ();

  instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .instr_master   (bus),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .fetch_busy     (fetch_busy)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    case (addr)
      32'h0:   rom_word = 32'h0070_8093;
      32'h4:   rom_word = 32'h0071_0113;
      32'h8:   rom_word = 32'h0020_81b3;
      default: rom_word = 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) bus.rd_data <= 32'h0;
    else if (bus.rd_req && bus.rd_gnt) bus.rd_data <= rom_word(bus.rd_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] data);
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h1);
    chk({tag, "_pc"}, instr_pc, pc);
    chk({tag, "_data"}, instr_data, data);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd_req"}, {31'h0, bus.rd_req}, 32'h0);
    chk({tag, "_rd_addr"}, bus.rd_addr, 32'h0);
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
    chk({tag, "_data"}, instr_data, 32'h0);
    chk({tag, "_pc"}, instr_pc, 32'h0);
    chk({tag, "_busy"}, {31'h0, fetch_busy}, 32'h0);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    instr_ready = 1'b0; bus.rd_gnt = 1'b0;
    cyc(); #1;
    chk_reset("reset");
    chk("reset_wr_req", {31'h0, bus.wr_req}, 32'h0);

    // straight-line fetch of the three ROM words
    cyc(); rst = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1; bus.rd_gnt = 1'b1; #1;
    chk("t1_idle_req", {31'h0, bus.rd_req}, 32'h0);
    cyc(); #1;
    chk("t1_c1_req", {31'h0, bus.rd_req}, 32'h1);
    chk("t1_c1_addr", bus.rd_addr, 32'h0);
    cyc(); #1;
    chk("t1_c2_addr", bus.rd_addr, 32'h4);
    chk("t1_c2_valid", {31'h0, instr_valid}, 32'h0);
    cyc(); #1; chk_head("t1_w0", 32'h0, 32'h0070_8093);
    cyc(); #1; chk_head("t1_w1", 32'h4, 32'h0071_0113);
    cyc(); #1; chk_head("t1_w2", 32'h8, 32'h0020_81b3);
    cyc(); #1; chk_head("t1_w3", 32'hC, 32'h0);

    // decode back-pressure for 6 cycles
    cyc(); instr_ready = 1'b0; #1;
    chk("t2_c7_req", {31'h0, bus.rd_req}, 32'h0);
    chk("t2_c7_pc", instr_pc, 32'h10);
    repeat (5) cyc();
    #1;
    chk("t2_hold_req", {31'h0, bus.rd_req}, 32'h0);
    chk("t2_hold_addr", bus.rd_addr, 32'h18);
    chk("t2_hold_pc", instr_pc, 32'h10);
    chk("t2_hold_busy", {31'h0, fetch_busy}, 32'h1);
    cyc(); instr_ready = 1'b1; #1;
    chk("t2_rel_req", {31'h0, bus.rd_req}, 32'h1);
    chk("t2_rel_addr", bus.rd_addr, 32'h18);
    chk("t2_rel_pc0", instr_pc, 32'h10);
    cyc(); #1; chk("t2_rel_pc1", instr_pc, 32'h14);
    cyc(); #1; chk("t2_rel_pc2", instr_pc, 32'h18);
    cyc(); #1; chk("t2_rel_pc3", instr_pc, 32'h1C);

    // redirect while the FIFO holds 0x8 and 0xC
    cyc(); rst = 1'b1; #1;
    cyc(); rst = 1'b0; #1;
    repeat (4) cyc();
    #1; chk_head("t3_d4", 32'h4, 32'h0071_0113);
    cyc(); instr_ready = 1'b0; #1;
    chk_head("t3_d5", 32'h8, 32'h0020_81b3);
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h6; #1;
    chk("t3_redir_req", {31'h0, bus.rd_req}, 32'h0);
    chk("t3_redir_pc", instr_pc, 32'h8);
    cyc(); redirect_valid = 1'b0; instr_ready = 1'b1; #1;
    chk("t3_flush_valid", {31'h0, instr_valid}, 32'h0);
    chk("t3_new_req", {31'h0, bus.rd_req}, 32'h1);
    chk("t3_new_addr", bus.rd_addr, 32'h4);
    cyc(); #1;
    chk("t3_d8_valid", {31'h0, instr_valid}, 32'h0);
    chk("t3_d8_addr", bus.rd_addr, 32'h8);
    cyc(); #1; chk_head("t3_first", 32'h4, 32'h0071_0113);
    cyc(); #1; chk_head("t3_second", 32'h8, 32'h0020_81b3);

    // grant withheld for 3 cycles
    cyc(); bus.rd_gnt = 1'b0; #1;
    chk("t4_g0_req", {31'h0, bus.rd_req}, 32'h1);
    chk("t4_g0_addr", bus.rd_addr, 32'h14);
    chk("t4_g0_pc", instr_pc, 32'hC);
    cyc(); #1;
    chk("t4_g1_addr", bus.rd_addr, 32'h14);
    chk("t4_g1_pc", instr_pc, 32'h10);
    cyc(); #1;
    chk("t4_g2_req", {31'h0, bus.rd_req}, 32'h1);
    chk("t4_g2_addr", bus.rd_addr, 32'h14);
    chk("t4_g2_valid", {31'h0, instr_valid}, 32'h0);
    cyc(); bus.rd_gnt = 1'b1; #1;
    chk("t4_gnt_addr", bus.rd_addr, 32'h14);
    cyc(); #1;
    chk("t4_next_addr", bus.rd_addr, 32'h18);
    chk("t4_gap_valid", {31'h0, instr_valid}, 32'h0);
    cyc(); #1; chk("t4_resume_pc0", instr_pc, 32'h14);
    cyc(); #1; chk("t4_resume_pc1", instr_pc, 32'h18);

    // fetch_en dropped with a word in flight
    cyc(); fetch_en = 1'b0; #1;
    chk("t5_stop_req", {31'h0, bus.rd_req}, 32'h0);
    chk("t5_stop_pc", instr_pc, 32'h1C);
    cyc(); #1;
    chk("t5_drain_busy", {31'h0, fetch_busy}, 32'h1);
    chk("t5_drain_req", {31'h0, bus.rd_req}, 32'h0);
    chk("t5_drain_pc", instr_pc, 32'h20);
    cyc(); #1;
    chk("t5_idle_busy", {31'h0, fetch_busy}, 32'h0);
    chk("t5_idle_valid", {31'h0, instr_valid}, 32'h0);
    chk("t5_idle_req", {31'h0, bus.rd_req}, 32'h0);
    cyc(); fetch_en = 1'b1; #1;
    chk("t5_restart_req", {31'h0, bus.rd_req}, 32'h0);
    cyc(); #1;
    chk("t5_restart_addr", bus.rd_addr, 32'h24);
    cyc(); cyc(); #1;
    chk("t5_mid_pc", instr_pc, 32'h24);
    #2; rst = 1'b1; #1;
    chk_reset("t5_async");

`ifdef FETCH_PERF_EN
    chk("t6_rst_fetch", perf_fetch_cnt, 32'h0);
    chk("t6_rst_stall", perf_stall_cnt, 32'h0);
    cyc(); rst = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1; bus.rd_gnt = 1'b1; #1;
    repeat (3) cyc();
    #1; chk_head("t6_w0", 32'h0, 32'h0070_8093);
    cyc(); instr_ready = 1'b0; #1;
    cyc(); #1;
    cyc(); instr_ready = 1'b1; #1;
    cyc(); cyc(); cyc(); #1;
    chk("t6_fetch_cnt", perf_fetch_cnt, 32'd4);
    chk("t6_stall_cnt", perf_stall_cnt, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
